vga_timing_gen: RTL and testbench

Display timing generator in the clk_in domain. Consumes the divided pixel-rate clock level from the clock divider stage as a synchronous data signal and detects its rising edges internally. Each detected rising edge is one pixel tick. Produces hsync, vsync, display-enable, pixel coordinates and line/frame start pulses for the pixel/video pipeline.

---
 rtl/vga_timing_gen.sv | 168 ++++++++++++++++
 tb/tb_vga_timing_gen.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Summary  : Display timing generator. Pixel ticks come from rising edges of
//            pix_clk_div sampled in the clk_in domain. Optional colour-bar
//            output on rgb when VGA_TEST_PATTERN_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int CNT_W    = 10
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             pix_clk_div,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_start,
  output logic             frame_start
`ifdef VGA_TEST_PATTERN_EN
  ,
  output logic [11:0]      rgb
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] c_H_LAST       = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] c_H_FP_START   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] c_H_SYNC_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] c_H_BP_START   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] c_V_LAST       = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] c_V_FP_START   = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] c_V_SYNC_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] c_V_BP_START   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_FRONT  = 2'd1,
    ST_SYNC   = 2'd2,
    ST_BACK   = 2'd3
  } region_t;

  function automatic region_t decode_region(
    input logic [CNT_W-1:0] cnt,
    input logic [CNT_W-1:0] fp_start,
    input logic [CNT_W-1:0] sync_start,
    input logic [CNT_W-1:0] bp_start
  );
    if (cnt < fp_start)        return ST_ACTIVE;
    else if (cnt < sync_start) return ST_FRONT;
    else if (cnt < bp_start)   return ST_SYNC;
    else                       return ST_BACK;
  endfunction

  logic             r_pix_q;
  logic             w_tick;
  logic             w_h_wrap;
  logic [CNT_W-1:0] r_hcnt;
  logic [CNT_W-1:0] r_vcnt;
  logic [CNT_W-1:0] w_hcnt_nxt;
  logic [CNT_W-1:0] w_vcnt_nxt;
  region_t          r_h_state;
  region_t          r_v_state;
  region_t          w_h_state_nxt;
  region_t          w_v_state_nxt;
  logic             w_de_nxt;

  // Regions are decoded from the post-tick counts so every output moves on
  // the same clk_in edge as the counters.
  always_comb begin
    w_tick        = pix_clk_div & ~r_pix_q;
    w_h_wrap      = (r_hcnt == c_H_LAST);
    w_hcnt_nxt    = r_hcnt;
    w_vcnt_nxt    = r_vcnt;
    w_h_state_nxt = r_h_state;
    w_v_state_nxt = r_v_state;
    if (w_tick) begin
      w_hcnt_nxt = w_h_wrap ? '0 : r_hcnt + CNT_W'(1);
      if (w_h_wrap) begin
        w_vcnt_nxt = (r_vcnt == c_V_LAST) ? '0 : r_vcnt + CNT_W'(1);
      end
      w_h_state_nxt = decode_region(w_hcnt_nxt, c_H_FP_START, c_H_SYNC_START, c_H_BP_START);
      w_v_state_nxt = decode_region(w_vcnt_nxt, c_V_FP_START, c_V_SYNC_START, c_V_BP_START);
    end
    w_de_nxt = (w_h_state_nxt == ST_ACTIVE) && (w_v_state_nxt == ST_ACTIVE);
  end

  // pix_q resets high so a level already high at release is not a tick.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_pix_q     <= 1'b1;
      r_hcnt      <= c_H_LAST;
      r_vcnt      <= c_V_LAST;
      r_h_state   <= ST_BACK;
      r_v_state   <= ST_BACK;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      r_pix_q     <= pix_clk_div;
      r_hcnt      <= w_hcnt_nxt;
      r_vcnt      <= w_vcnt_nxt;
      r_h_state   <= w_h_state_nxt;
      r_v_state   <= w_v_state_nxt;
      hsync       <= (w_h_state_nxt == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
      vsync       <= (w_v_state_nxt == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
      de          <= w_de_nxt;
      line_start  <= w_tick && (w_hcnt_nxt == '0);
      frame_start <= w_tick && (w_hcnt_nxt == '0) && (w_vcnt_nxt == '0);
      if (w_tick) begin
        x <= w_hcnt_nxt;
        y <= w_vcnt_nxt;
      end
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;

  logic [7:1] w_bar_ge;
  logic [11:0] w_colour;

  // Thermometer of bar boundaries; comparators avoid a divider.
  generate
    for (genvar k = 1; k < 8; k++) begin : g_bar_cmp
      assign w_bar_ge[k] = (w_hcnt_nxt >= CNT_W'(k * BAR_W));
    end
  endgenerate

  always_comb begin
    w_colour = 12'hFFF;
    if (w_bar_ge[7])      w_colour = 12'h000;
    else if (w_bar_ge[6]) w_colour = 12'h00F;
    else if (w_bar_ge[5]) w_colour = 12'hF00;
    else if (w_bar_ge[4]) w_colour = 12'hF0F;
    else if (w_bar_ge[3]) w_colour = 12'h0F0;
    else if (w_bar_ge[2]) w_colour = 12'h0FF;
    else if (w_bar_ge[1]) w_colour = 12'hFF0;
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      rgb <= 12'h000;
    end else if (w_tick) begin
      rgb <= w_de_nxt ? w_colour : 12'h000;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// Directed bench for vga_timing_gen: a small 16x8 configuration with a
// reference model, plus a default 640x480 instance for horizontal timing.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pix = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [9:0] s_x, s_y, d_x, d_y;
  logic s_hs, s_vs, s_de, s_ls, s_fs;
  logic d_hs, d_vs, d_de, d_ls, d_fs;
`ifdef VGA_TEST_PATTERN_EN
  logic [11:0] s_rgb, d_rgb, da_rgb;
`endif

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b0), .CNT_W(10)
  ) u_small (
    .clk_in(clk), .reset(reset), .pix_clk_div(pix),
    .hsync(s_hs), .vsync(s_vs), .de(s_de), .x(s_x), .y(s_y),
    .line_start(s_ls), .frame_start(s_fs)
`ifdef VGA_TEST_PATTERN_EN
    , .rgb(s_rgb)
`endif
  );

  vga_timing_gen u_default (
    .clk_in(clk), .reset(reset), .pix_clk_div(pix),
    .hsync(d_hs), .vsync(d_vs), .de(d_de), .x(d_x), .y(d_y),
    .line_start(d_ls), .frame_start(d_fs)
`ifdef VGA_TEST_PATTERN_EN
    , .rgb(d_rgb)
`endif
  );

  localparam logic [24:0] RESET_VEC = {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  int eh = 15, ev = 7;
  int a_cyc;
  int last_ls = -1, last_fs = -1;
  logic [24:0] a_vec, b_vec;
  logic [9:0] da_x, da_y;
  logic da_de, da_hs, da_vs, da_ls;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [24:0] small_vec();
    return {s_x, s_y, s_de, s_hs, s_vs, s_ls, s_fs};
  endfunction

  // Expected outputs of the 16x8 config at counter position (h,v).
  function automatic logic [24:0] exp_small(input int h, input int v);
    return {10'(h), 10'(v), 1'(h < 8 && v < 4), 1'(!(h >= 10 && h <= 12)),
            1'(!(v >= 5 && v <= 6)), 1'(h == 0), 1'(h == 0 && v == 0)};
  endfunction

  function automatic void model_tick();
    eh = (eh == 15) ? 0 : eh + 1;
    if (eh == 0) ev = (ev == 7) ? 0 : ev + 1;
  endfunction

  // One pixel tick: pix high for hi cycles, low for lo cycles. a_* is the
  // cycle after the rising edge, b_vec the cycle after that.
  task automatic do_tick(input int hi, input int lo);
    pix = 1'b1;
    step();
    a_vec = small_vec();
    a_cyc = cyc;
    da_x = d_x; da_y = d_y; da_de = d_de; da_hs = d_hs; da_vs = d_vs; da_ls = d_ls;
`ifdef VGA_TEST_PATTERN_EN
    da_rgb = d_rgb;
`endif
    for (int i = 1; i < hi + lo; i++) begin
      if (i == hi) pix = 1'b0;
      step();
      if (i == 1) b_vec = small_vec();
    end
  endtask

  // Per-tick comparison of the small instance against the model.
  task automatic small_tick(input int hi, input int lo, input int ls_gap);
    logic [24:0] e;
    model_tick();
    do_tick(hi, lo);
    e = exp_small(eh, ev);
    n_checks++;
    if (a_vec !== e) $display("FAIL tick(%0d,%0d) got %h want %h", eh, ev, a_vec, e);
    else n_pass++;
    n_checks++;
    if (b_vec !== {e[24:2], 2'b00}) $display("FAIL hold(%0d,%0d) got %h want %h", eh, ev, b_vec, {e[24:2], 2'b00});
    else n_pass++;
    if (eh == 0) begin
      if (last_ls >= 0 && ls_gap > 0) begin
        n_checks++;
        if (a_cyc - last_ls !== ls_gap) $display("FAIL line_period got %0d want %0d", a_cyc - last_ls, ls_gap);
        else n_pass++;
      end
      last_ls = a_cyc;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; pix = 1'b1;
    repeat (3) step();
    n_checks++;
    if (small_vec() !== RESET_VEC) $display("FAIL reset_vals got %h want %h", small_vec(), RESET_VEC);
    else n_pass++;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (small_vec() !== RESET_VEC) $display("FAIL high_at_release got %h want %h", small_vec(), RESET_VEC);
      else n_pass++;
    end
    pix = 1'b0;
    step();
    eh = 15; ev = 7;
    small_tick(2, 2, 0);
    n_checks++;
    if (a_vec[1:0] !== 2'b11) $display("FAIL first_pulses got %b want 11", a_vec[1:0]);
    else n_pass++;
    last_fs = a_cyc;
  endtask

  task automatic test_line();
    for (int i = 0; i < 16; i++) small_tick(2, 2, 64);
  endtask

  task automatic test_frame();
    for (int i = 0; i < 112; i++) begin
      small_tick(2, 2, 64);
      if (eh == 0 && ev == 0) begin
        n_checks++;
        if (a_cyc - last_fs !== 512) $display("FAIL frame_period got %0d want 512", a_cyc - last_fs);
        else n_pass++;
        last_fs = a_cyc;
      end
    end
    n_checks++;
    if (last_fs < 0 || a_vec[1:0] !== 2'b11) $display("FAIL frame_wrap got %b want 11", a_vec[1:0]);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    last_ls = -1;
    for (int i = 0; i < 40; i++) small_tick(1, 1, 32);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 200 && !(eh == 5 && ev == 2); i++) small_tick(2, 2, 0);
    n_checks++;
    if (small_vec() !== exp_small(5, 2) & ~25'b11) $display("FAIL pre_reset got %h want %h", small_vec(), exp_small(5, 2) & ~25'b11);
    else n_pass++;
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    n_checks++;
    if (small_vec() !== RESET_VEC) $display("FAIL async_reset got %h want %h", small_vec(), RESET_VEC);
    else n_pass++;
    step();
    step();
    reset = 1'b0;
    step();
    eh = 15; ev = 7; last_ls = -1;
    small_tick(2, 2, 0);
    n_checks++;
    if (a_vec !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1}) $display("FAIL post_reset_first got %h", a_vec);
    else n_pass++;
  endtask

  task automatic test_default();
    int low_cnt = 0, first_low = -1, d_last = -1;
    reset = 1'b1; pix = 1'b0;
    step(); step();
    reset = 1'b0;
    step();
    eh = 15; ev = 7; last_ls = -1;
    for (int k = 0; k <= 800; k++) begin
      small_tick(2, 2, 64);
      if (!da_hs) begin
        low_cnt++;
        if (first_low < 0) first_low = k;
      end
      if (k == 0 || k == 800) begin
        n_checks++;
        if ({da_x, da_y, da_ls, da_de, da_vs} !== {10'd0, 10'(k / 800), 1'b1, 1'b1, 1'b1})
          $display("FAIL dflt_line%0d got x=%0d y=%0d ls=%b de=%b vs=%b", k, da_x, da_y, da_ls, da_de, da_vs);
        else n_pass++;
        if (k == 800) begin
          n_checks++;
          if (a_cyc - d_last !== 3200) $display("FAIL dflt_line_period got %0d want 3200", a_cyc - d_last);
          else n_pass++;
        end
        d_last = a_cyc;
      end
      case (k)
        639, 640: begin
          n_checks++;
          if (da_de !== (k == 639)) $display("FAIL dflt_de x=%0d got %b want %b", k, da_de, k == 639);
          else n_pass++;
        end
        655, 656, 751, 752: begin
          n_checks++;
          if (da_hs !== (k == 655 || k == 752)) $display("FAIL dflt_hsync x=%0d got %b", k, da_hs);
          else n_pass++;
        end
        default: ;
      endcase
`ifdef VGA_TEST_PATTERN_EN
      begin
        logic [11:0] er;
        er = 12'hxxx;
        case (k)
          0, 79: er = 12'hFFF;
          80: er = 12'hFF0;
          160: er = 12'h0FF;
          240: er = 12'h0F0;
          320: er = 12'hF0F;
          400: er = 12'hF00;
          480, 559: er = 12'h00F;
          560, 639, 640, 700: er = 12'h000;
          default: ;
        endcase
        if (er !== 12'hxxx) begin
          n_checks++;
          if (da_rgb !== er) $display("FAIL rgb x=%0d got %h want %h", k, da_rgb, er);
          else n_pass++;
        end
      end
`endif
    end
    n_checks++;
    if (low_cnt !== 96 || first_low !== 656) $display("FAIL dflt_hsync_width got %0d@%0d want 96@656", low_cnt, first_low);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_back_to_back();
    test_reset_mid();
    test_default();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
